xgmii_rx_framer: RTL and testbench
==================================

// Module: xgmii_rx_framer
// PURPOSE
//  Per-port receive framer between the XGMII RX output of network_path/xgmii2fifo72 and the l2switch ingress FIFO.
//  Finds /S/..T/ frames in the 64-bit XGMII stream and strips preamble/SFD.
//  Emits 64-bit data words with byte enables and SOF/EOF/ERR tags.
//  Drops frames when the ingress FIFO is almost full and maintains per-port frame, drop and error counters.
// PARAMETERS
//  MIN_BYTES  64    shortest legal frame incl. FCS; shorter frames are tagged ERR
//  MAX_BYTES  1518  longest legal frame incl. FCS; reaching MAX_BYTES+8 with no /T/ aborts the frame with ERR
//  CNT_W      32    width of statistics counters
// PORTS
//  xgmii_rx_clk  in   1      156.25 MHz XGMII RX clock; all logic on rising edge
//  sys_rst_n     in   1      asynchronous active-low reset
//  xgmii_rxd     in   64     XGMII data, lane k = bits [8k+7:8k], lane 0 first on wire
//  xgmii_rxc     in   8      XGMII control, bit k flags lane k as control char
//  out_full      in   1      ingress FIFO almost-full; headroom >= MAX_BYTES/8+4 words
//  out_valid     out  1      output word strobe (FIFO wr_en)
//  out_data      out  64     frame bytes, same lane order as input
//  out_be        out  8      byte enables, contiguous from lane 0
//  out_sof       out  1      first word of frame (its lane 0 = DA byte 0)
//  out_eof       out  1      last word of frame
//  out_err       out  1      valid only with out_eof; frame is bad, downstream discards
//  frame_cnt     out  CNT_W  good frames delivered
//  drop_cnt      out  CNT_W  frames not delivered (full at /S/, bad preamble)
//  err_cnt       out  CNT_W  frames delivered with out_err
// BEHAVIOUR
//  Control chars: /S/=FB, /T/=FD, /E/=FE, /I/=07. /S/ is recognised in lane 0 only; the upstream aligner guarantees this.
//  Start word requires: lane0 = FB with rxc=01; lanes1-6 = 55; lane7 = D5.
//  States:
//   IDLE: on a valid start word, go to DATA if !out_full.
//     - If out_full: go to DROP, drop_cnt++.
//     - On bad preamble: go to DROP, drop_cnt++.
//   DATA: each all-data word (rxc=00) is loaded into the hold register. The previous hold word is emitted.
//     - First emitted word has out_sof=1; be=FF.
//   DATA, /T/ in lane k>0 with lanes 0..k-1 data:
//     - Emit the hold word, then the T word with be=(1<<k)-1, eof=1.
//     - Go to IDLE.
//   DATA, /T/ in lane 0: the hold word is emitted with eof=1, be=FF. Go to IDLE.
//   DATA, error event: any /E/, any other control char, /S/ in lane 0, or byte count reaching MAX_BYTES+8.
//     - Emit the hold word with eof=1, err=1. Remaining data bytes of this word are not emitted.
//     - On /S/ restart: go to IDLE logic for that word in the same cycle.
//     - On other errors: go to DROP. err_cnt++.
//   DROP: emit nothing until a word containing /T/ or rxc=FF (idle). Then go to IDLE.
//  Byte count: 14-bit, cleared at /S/, incremented by data bytes, saturates.
//   - At eof, count < MIN_BYTES or > MAX_BYTES: err=1, err_cnt++.
//   - Otherwise frame_cnt++.
//  Latency: a data word entering at cycle t appears on out_* at cycle t+2 (hold reg + output reg).
//   - out_valid is never asserted two cycles after an idle/start word.
//  out_full is sampled only at /S/. Mid-frame writes are unconditional; the headroom requirement covers them.
//  Back-to-back: /T/ word then /S/ in the next word is accepted. /T/ and /S/ in the same word are not supported: the frame is dropped.
//  Counters wrap at 2^CNT_W. An increment in the same cycle as another counter's increment is applied independently.
//  Reset (any time, including mid-frame):
//   - all out_* = 0, counters = 0, state = IDLE, hold reg invalid.
//   - No partial EOF is emitted after reset; the first frame after reset needs a fresh /S/.
// TESTING
//  1) 64B frame: /S/ word, 8 data words, T in lane0 -> 8 words, sof on #1, eof on #8, be=FF, err=0, frame_cnt=1.
//  2) 65B frame: T in lane1 -> 9 words, last be=01, eof=1, err=0. First out_valid 2 cycles after first data word.
//  3) out_full=1 during /S/, low afterwards -> no out_valid for the frame, drop_cnt=1. Next frame delivered normally.
//  4) /E/ in lane3 of the 4th data word -> word 3 emitted with eof=1 err=1, err_cnt=1. Rest dropped until T.
//  5) 40B runt, plus 2000B frame without T -> runt: eof err=1. Long frame: aborted with err at byte 1526. err_cnt=2.
//  6) sys_rst_n low mid-frame for 3 cycles, then two back-to-back 64B frames -> outputs 0 during reset, frame_cnt=2.

Source files
------------

// File: rtl/xgmii_rx_framer_if.sv
// XGMII receive bus plus the framed word stream towards the l2switch ingress FIFO.
// The framer takes the master view; the FIFO side (or a testbench) takes the slave view.
interface xgmii_rx_framer_if;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic        out_full;
  logic        out_valid;
  logic [63:0] out_data;
  logic [7:0]  out_be;
  logic        out_sof;
  logic        out_eof;
  logic        out_err;

  modport master (
    input  xgmii_rxd, xgmii_rxc, out_full,
    output out_valid, out_data, out_be, out_sof, out_eof, out_err
  );

  modport slave (
    output xgmii_rxd, xgmii_rxc, out_full,
    input  out_valid, out_data, out_be, out_sof, out_eof, out_err
  );
endinterface

// File: rtl/xgmii_rx_framer.sv
// Per-port XGMII receive framer: finds /S/../T/ frames, strips preamble/SFD and emits
// tagged 64-bit words for the ingress FIFO, with frame/drop/error statistics.
module xgmii_rx_framer #(
  parameter int MIN_BYTES = 64,
  parameter int MAX_BYTES = 1518,
  parameter int CNT_W     = 32
) (
  input  logic             xgmii_rx_clk,
  input  logic             sys_rst_n,
  xgmii_rx_framer_if.master bus,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [13:0] MIN_L   = 14'(MIN_BYTES);
  localparam logic [13:0] MAX_L   = 14'(MAX_BYTES);
  localparam logic [14:0] ABORT_L = 15'(MAX_BYTES + 8);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DROP} state_t;

  state_t      state, state_nx;
  logic [13:0] byte_cnt, cnt_nx;
  logic        sof_pend, sof_pend_nx;
  logic [63:0] hold_data;
  logic [7:0]  hold_be;
  logic        hold_valid;

  logic [63:0] rxd;
  logic [7:0]  rxc;
  logic        is_s0, pre_ok, has_e, any_t, t_first, abort;
  logic [2:0]  first_k;
  logic [14:0] sum_data, sum_t;

  logic        emit, emit_eof, emit_err;
  logic        hold_ld, hold_clr, start_chk, drop_inc;
  logic [7:0]  ld_be;
  logic        frame_inc, err_inc;

  assign rxd      = bus.xgmii_rxd;
  assign rxc      = bus.xgmii_rxc;
  assign is_s0    = rxc[0] && (rxd[7:0] == 8'hFB);
  assign pre_ok   = (rxc == 8'h01) && (rxd[63:8] == {8'hD5, 48'h5555_5555_5555});
  assign sum_data = {1'b0, byte_cnt} + 15'd8;
  assign sum_t    = {1'b0, byte_cnt} + {12'd0, first_k};
  assign abort    = (rxc == 8'h00) && (sum_data >= ABORT_L);

  // Lowest control lane decides whether a word terminates the frame cleanly.
  always_comb begin
    first_k = 3'd0;
    has_e   = 1'b0;
    any_t   = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (rxc[k]) begin
        first_k = 3'(k);
        if (rxd[8*k +: 8] == 8'hFE) has_e = 1'b1;
        if (rxd[8*k +: 8] == 8'hFD) any_t = 1'b1;
      end
    end
    t_first = (|rxc) && (rxd[8*first_k +: 8] == 8'hFD);
  end

  always_ff @(posedge xgmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      sof_pend   <= 1'b0;
      hold_data  <= '0;
      hold_be    <= '0;
      hold_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      byte_cnt <= cnt_nx;
      sof_pend <= sof_pend_nx;
      if (hold_ld) begin
        hold_data  <= rxd;
        hold_be    <= ld_be;
        hold_valid <= 1'b1;
      end else if (hold_clr) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // A pending hold word in IDLE is the partial /T/ word of the frame that just ended.
  always_comb begin
    state_nx    = state;
    cnt_nx      = byte_cnt;
    sof_pend_nx = sof_pend;
    emit        = 1'b0;
    emit_eof    = 1'b0;
    emit_err    = 1'b0;
    hold_ld     = 1'b0;
    hold_clr    = 1'b0;
    ld_be       = 8'hFF;
    start_chk   = 1'b0;
    drop_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_valid) begin
          emit     = 1'b1;
          emit_eof = 1'b1;
          hold_clr = 1'b1;
        end
        start_chk = 1'b1;
      end
      ST_DATA: begin
        if ((rxc == 8'h00) && !abort) begin
          emit    = hold_valid;
          hold_ld = 1'b1;
          cnt_nx  = sum_data[14] ? 14'h3FFF : sum_data[13:0];
        end else if (is_s0) begin
          emit      = hold_valid;
          emit_eof  = 1'b1;
          emit_err  = 1'b1;
          hold_clr  = 1'b1;
          state_nx  = ST_IDLE;
          start_chk = 1'b1;
        end else if ((rxc == 8'h00) || has_e || !t_first) begin
          emit     = hold_valid;
          emit_eof = 1'b1;
          emit_err = 1'b1;
          hold_clr = 1'b1;
          state_nx = ST_DROP;
        end else if (first_k == 3'd0) begin
          emit     = hold_valid;
          emit_eof = 1'b1;
          hold_clr = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          emit     = hold_valid;
          hold_ld  = 1'b1;
          ld_be    = (8'd1 << first_k) - 8'd1;
          cnt_nx   = sum_t[14] ? 14'h3FFF : sum_t[13:0];
          state_nx = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (any_t || (rxc == 8'hFF)) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase

    if (emit) sof_pend_nx = 1'b0;
    if (emit && emit_eof && !emit_err && ((byte_cnt < MIN_L) || (byte_cnt > MAX_L)))
      emit_err = 1'b1;

    if (start_chk && is_s0) begin
      if (pre_ok && !bus.out_full) begin
        state_nx    = ST_DATA;
        cnt_nx      = '0;
        sof_pend_nx = 1'b1;
      end else begin
        state_nx = ST_DROP;
        drop_inc = 1'b1;
      end
    end
  end

  assign frame_inc = emit && emit_eof && !emit_err;
  assign err_inc   = emit && emit_eof && emit_err;

  always_ff @(posedge xgmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_be    <= '0;
      bus.out_sof   <= 1'b0;
      bus.out_eof   <= 1'b0;
      bus.out_err   <= 1'b0;
      frame_cnt     <= '0;
      drop_cnt      <= '0;
      err_cnt       <= '0;
    end else begin
      bus.out_valid <= emit;
      bus.out_data  <= emit ? hold_data : '0;
      bus.out_be    <= emit ? hold_be : '0;
      bus.out_sof   <= emit && sof_pend;
      bus.out_eof   <= emit && emit_eof;
      bus.out_err   <= emit && emit_err;
      if (frame_inc) frame_cnt <= frame_cnt + 1'b1;
      if (drop_inc)  drop_cnt  <= drop_cnt + 1'b1;
      if (err_inc)   err_cnt   <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_xgmii_rx_framer.sv
// Directed bench for xgmii_rx_framer: drives hand-built XGMII words and checks
// captured output words and statistics against hand-computed expectations.
module tb_xgmii_rx_framer;

  localparam logic [63:0] START_D = {8'hD5, 48'h5555_5555_5555, 8'hFB};
  localparam logic [63:0] IDLE_D  = {8{8'h07}};

  logic        xgmii_rx_clk = 1'b0;
  logic        sys_rst_n    = 1'b0;
  logic [31:0] frame_cnt, drop_cnt, err_cnt;

  xgmii_rx_framer_if bus();

  xgmii_rx_framer dut (
    .xgmii_rx_clk (xgmii_rx_clk),
    .sys_rst_n    (sys_rst_n),
    .bus          (bus),
    .frame_cnt    (frame_cnt),
    .drop_cnt     (drop_cnt),
    .err_cnt      (err_cnt)
  );

  always #3 xgmii_rx_clk = ~xgmii_rx_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [63:0] cap_data[$];
  logic [7:0]  cap_be[$];
  bit          cap_sof[$];
  bit          cap_eof[$];
  bit          cap_err[$];
  int          cap_cyc[$];

  always @(posedge xgmii_rx_clk) cyc <= cyc + 1;

  // Outputs are sampled on the falling edge, away from the register updates.
  always @(negedge xgmii_rx_clk) begin
    if (bus.out_valid) begin
      cap_data.push_back(bus.out_data);
      cap_be.push_back(bus.out_be);
      cap_sof.push_back(bus.out_sof);
      cap_eof.push_back(bus.out_eof);
      cap_err.push_back(bus.out_err);
      cap_cyc.push_back(cyc);
    end
  end

  function automatic logic [63:0] dataWord(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8{b}} ^ 64'h0706_0504_0302_0100;
  endfunction

  function automatic logic [63:0] termD(input int k);
    logic [63:0] w;
    for (int l = 0; l < 8; l++) begin
      if (l < k)       w[8*l +: 8] = 8'hA0 + 8'(l);
      else if (l == k) w[8*l +: 8] = 8'hFD;
      else             w[8*l +: 8] = 8'h07;
    end
    return w;
  endfunction

  function automatic logic [7:0] termC(input int k);
    return 8'hFF << k;
  endfunction

  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] c);
    @(negedge xgmii_rx_clk);
    bus.xgmii_rxd = d;
    bus.xgmii_rxc = c;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sendData(input int n);
    for (int i = 0; i < n; i++) applyStimulus(dataWord(i), 8'h00);
  endtask

  task automatic sendIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(IDLE_D, 8'hFF);
  endtask

  task automatic clearCap();
    cap_data.delete(); cap_be.delete(); cap_sof.delete();
    cap_eof.delete(); cap_err.delete(); cap_cyc.delete();
  endtask

  task automatic checkFrame(input string tag, input int n_words, input logic [7:0] last_be,
                            input bit last_err);
    int last;
    int eofs;
    checkOutput({tag, ".words"}, 64'(cap_data.size()), 64'(n_words));
    if (cap_data.size() > 0) begin
      last = cap_data.size() - 1;
      eofs = 0;
      foreach (cap_eof[i]) eofs += int'(cap_eof[i]);
      checkOutput({tag, ".sof0"}, 64'(cap_sof[0]), 64'd1);
      checkOutput({tag, ".data0"}, cap_data[0], dataWord(0));
      checkOutput({tag, ".eof_last"}, 64'(cap_eof[last]), 64'd1);
      checkOutput({tag, ".eof_count"}, 64'(eofs), 64'd1);
      checkOutput({tag, ".be_last"}, 64'(cap_be[last]), 64'(last_be));
      checkOutput({tag, ".err_last"}, 64'(cap_err[last]), 64'(last_err));
    end
  endtask

  initial begin
    int d0_cyc;
    bus.xgmii_rxd = IDLE_D;
    bus.xgmii_rxc = 8'hFF;
    bus.out_full  = 1'b0;

    $display("[TB] reset state");
    sendIdle(3);
    checkOutput("rst.valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst.frame_cnt", 64'(frame_cnt), 64'd0);
    sys_rst_n = 1'b1;
    sendIdle(2);

    $display("[TB] 64B frame, T in lane 0");
    clearCap();
    applyStimulus(START_D, 8'h01);
    sendData(8);
    applyStimulus(termD(0), termC(0));
    sendIdle(4);
    checkFrame("t1", 8, 8'hFF, 1'b0);
    if (cap_data.size() == 8) checkOutput("t1.data7", cap_data[7], dataWord(7));
    checkOutput("t1.frame_cnt", 64'(frame_cnt), 64'd1);

    $display("[TB] 65B frame, T in lane 1, back-to-back 64B frame");
    clearCap();
    applyStimulus(START_D, 8'h01);
    applyStimulus(dataWord(0), 8'h00);
    d0_cyc = cyc;
    for (int i = 1; i < 8; i++) applyStimulus(dataWord(i), 8'h00);
    applyStimulus(termD(1), termC(1));
    applyStimulus(START_D, 8'h01);
    sendData(8);
    applyStimulus(termD(0), termC(0));
    sendIdle(4);
    checkOutput("t2.words", 64'(cap_data.size()), 64'd17);
    if (cap_data.size() == 17) begin
      checkOutput("t2.latency", 64'(cap_cyc[0] - d0_cyc), 64'd2);
      checkOutput("t2.be7", 64'(cap_be[7]), 64'hFF);
      checkOutput("t2.eof7", 64'(cap_eof[7]), 64'd0);
      checkOutput("t2.be8", 64'(cap_be[8]), 64'h01);
      checkOutput("t2.eof8", 64'(cap_eof[8]), 64'd1);
      checkOutput("t2.err8", 64'(cap_err[8]), 64'd0);
      checkOutput("t2.byte64", 64'(cap_data[8][7:0]), 64'hA0);
      checkOutput("t2.sof9", 64'(cap_sof[9]), 64'd1);
      checkOutput("t2.eof16", 64'(cap_eof[16]), 64'd1);
    end
    checkOutput("t2.frame_cnt", 64'(frame_cnt), 64'd3);

    $display("[TB] out_full at /S/");
    clearCap();
    bus.out_full = 1'b1;
    applyStimulus(START_D, 8'h01);
    applyStimulus(dataWord(0), 8'h00);
    bus.out_full = 1'b0;
    sendData(7);
    applyStimulus(termD(0), termC(0));
    sendIdle(3);
    checkOutput("t3.words", 64'(cap_data.size()), 64'd0);
    checkOutput("t3.drop_cnt", 64'(drop_cnt), 64'd1);
    applyStimulus(START_D, 8'h01);
    sendData(8);
    applyStimulus(termD(0), termC(0));
    sendIdle(4);
    checkFrame("t3b", 8, 8'hFF, 1'b0);
    checkOutput("t3b.frame_cnt", 64'(frame_cnt), 64'd4);

    $display("[TB] bad SFD");
    clearCap();
    applyStimulus({8'hD4, START_D[55:0]}, 8'h01);
    sendData(8);
    applyStimulus(termD(0), termC(0));
    sendIdle(3);
    checkOutput("pre.words", 64'(cap_data.size()), 64'd0);
    checkOutput("pre.drop_cnt", 64'(drop_cnt), 64'd2);

    $display("[TB] /E/ in lane 3 of 4th data word");
    clearCap();
    applyStimulus(START_D, 8'h01);
    sendData(3);
    applyStimulus({32'h1111_1111, 8'hFE, 24'h22_2222}, 8'h08);
    sendData(2);
    applyStimulus(termD(0), termC(0));
    sendIdle(3);
    checkFrame("t4", 3, 8'hFF, 1'b1);
    checkOutput("t4.err_cnt", 64'(err_cnt), 64'd1);
    checkOutput("t4.frame_cnt", 64'(frame_cnt), 64'd4);

    $display("[TB] 40B runt and overlong frame");
    clearCap();
    applyStimulus(START_D, 8'h01);
    sendData(5);
    applyStimulus(termD(0), termC(0));
    sendIdle(3);
    checkFrame("t5a", 5, 8'hFF, 1'b1);
    checkOutput("t5a.err_cnt", 64'(err_cnt), 64'd2);
    clearCap();
    applyStimulus(START_D, 8'h01);
    sendData(250);
    sendIdle(3);
    checkFrame("t5b", 190, 8'hFF, 1'b1);
    if (cap_data.size() == 190) checkOutput("t5b.data189", cap_data[189], dataWord(189));
    checkOutput("t5b.err_cnt", 64'(err_cnt), 64'd3);
    checkOutput("t5b.frame_cnt", 64'(frame_cnt), 64'd4);

    $display("[TB] reset mid-frame, then back-to-back frames");
    applyStimulus(START_D, 8'h01);
    sendData(3);
    sys_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(IDLE_D, 8'hFF);
      checkOutput("t6.rst_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("t6.rst_eof", 64'(bus.out_eof), 64'd0);
      checkOutput("t6.rst_cnts", 64'(frame_cnt | drop_cnt | err_cnt), 64'd0);
    end
    sys_rst_n = 1'b1;
    sendData(2);
    sendIdle(2);
    checkOutput("t6.no_partial", 64'(err_cnt), 64'd0);
    clearCap();
    applyStimulus(START_D, 8'h01);
    sendData(8);
    applyStimulus(termD(0), termC(0));
    applyStimulus(START_D, 8'h01);
    sendData(8);
    applyStimulus(termD(0), termC(0));
    sendIdle(4);
    checkOutput("t6.words", 64'(cap_data.size()), 64'd16);
    if (cap_data.size() == 16) begin
      checkOutput("t6.sof0", 64'(cap_sof[0]), 64'd1);
      checkOutput("t6.eof7", 64'(cap_eof[7]), 64'd1);
      checkOutput("t6.sof8", 64'(cap_sof[8]), 64'd1);
      checkOutput("t6.err15", 64'(cap_err[15]), 64'd0);
    end
    checkOutput("t6.frame_cnt", 64'(frame_cnt), 64'd2);
    checkOutput("t6.drop_cnt", 64'(drop_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
